matrix_slot_manager: RTL and testbench
======================================

MATRIX_SLOT_MANAGER -- requirements
Module: matrix_slot_manager

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, BRAM element address width; SHALL be >= 12.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 alloc_req  input  1  level request from a generator for one slot.
REQ-005 alloc_valid  output  1  one-cycle grant pulse.
REQ-006 alloc_slot  output  4  granted slot index, valid with alloc_valid.
REQ-007 alloc_addr  output  ADDR_WIDTH  granted base address, valid with alloc_valid.
REQ-008 commit_req  input  1  one-cycle commit strobe.
REQ-009 commit_slot / commit_m / commit_n / commit_addr  input  4/5/5/ADDR_WIDTH  commit payload, sampled with commit_req.
REQ-010 free_req  input  1  one-cycle release strobe; free_slot  input  4  slot to release.
REQ-011 timeout_reset  input  1  abort; releases all uncommitted reservations.
REQ-012 qry_slot  input  4  query index; qry_valid / qry_m / qry_n / qry_addr  output  1/5/5/ADDR_WIDTH  registered query result.
REQ-013 valid_mask  output  16  bit i = slot i committed; valid_count  output  5  popcount of valid_mask.
REQ-014 alloc_full  output  1  no slot grantable; evict_pulse  output  1  grant reused a committed slot; commit_err  output  1  one-cycle commit rejection.

Function
REQ-015 Each of 16 slots SHALL hold status FREE/RESERVED/VALID, m[4:0], n[4:0]; base address SHALL be fixed at slot<<8 (256 elements per slot), zero-extended to ADDR_WIDTH.
REQ-016 Grant FSM states SHALL be IDLE, SCAN, GRANT, HOLD.
REQ-017 IDLE: alloc_req=1 -> SCAN.
REQ-018 SCAN, choice order: lowest-index FREE slot; else first VALID slot at or after victim_ptr, circular; else none.
REQ-019 SCAN with a choice: latch slot, set its status RESERVED, -> GRANT; on VALID reuse, victim_ptr <= chosen+1 (mod 16), evict_pulse=1 for one cycle.
REQ-020 SCAN with no choice (all RESERVED): alloc_full=1, remain in SCAN; alloc_req=0 -> IDLE.
REQ-021 GRANT: alloc_valid=1 for exactly one cycle with alloc_slot/alloc_addr -> HOLD; grant latency is 2 cycles after the first cycle alloc_req is sampled high.
REQ-022 HOLD: remain until alloc_req=0, then -> IDLE; no second grant while alloc_req stays high after a grant.
REQ-023 Commit accepted only if slot status is RESERVED, 1<=commit_m<=16, 1<=commit_n<=16 and commit_addr equals slot base; on acceptance status <= VALID and m/n are stored.
REQ-024 Rejected commit: slot unchanged, commit_err=1 for one cycle.
REQ-025 free_req: slot status <= FREE regardless of prior state; FREE of a FREE slot is a no-op.
REQ-026 Simultaneous free_req and commit_req on the same slot: free wins, commit_err=1.
REQ-027 Commit/free updates in cycle k SHALL be visible to a SCAN in cycle k+1, not in cycle k.
REQ-028 timeout_reset=1: every RESERVED slot -> FREE, FSM -> IDLE, alloc_valid=0 that cycle; VALID slots unchanged; overrides alloc, commit and free that cycle.
REQ-029 Query: qry_* SHALL reflect slot qry_slot one cycle later; qry_valid=1 only for VALID; qry_m/n/addr=0 otherwise.
REQ-030 valid_mask, valid_count and alloc_full SHALL be registered and consistent with slot state the cycle after any change.

Reset
REQ-031 rst=1 SHALL immediately force all slots FREE with m=n=0, victim_ptr=0, FSM IDLE.
REQ-032 Reset values: alloc_valid=0, alloc_slot=0, alloc_addr=0, qry_*=0, valid_mask=0, valid_count=0, alloc_full=0, evict_pulse=0, commit_err=0.
REQ-033 Reset asserted mid-grant SHALL drop alloc_valid asynchronously; no reservation survives.

Verification
REQ-034 After reset, alloc_req held high -> alloc_valid pulse 2 cycles later, slot 0, addr 0x000; no second pulse while alloc_req stays high.
REQ-035 Grant slot 0, commit (slot 0, m=3, n=4, addr 0) -> valid_mask=0x0001, valid_count=1; qry_slot=0 -> qry_valid=1, qry_m=3, qry_n=4.
REQ-036 Commit slot 2 while FREE, or m=17 on a reserved slot -> commit_err pulse, valid_mask unchanged.
REQ-037 All 16 slots VALID, victim_ptr=0, new request -> slot 0 granted, evict_pulse=1, next request -> slot 1.
REQ-038 16 slots RESERVED, then request -> alloc_full=1, no grant; timeout_reset -> all FREE, next request grants slot 0.
REQ-039 Free and commit on slot 5 in same cycle -> slot 5 FREE, commit_err=1, valid_mask bit 5 = 0.

Source files
------------

// File: rtl/matrix_slot_manager.sv
// Matrix slot manager: 16 fixed-size BRAM slots (256 elements each) that
// generators reserve through a grant FSM, then commit with matrix dimensions
// or release. Committed slots are recycled round-robin once no slot is free.
module matrix_slot_manager #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    output logic                  alloc_valid,
    output logic [3:0]            alloc_slot,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    input  logic                  commit_req,
    input  logic [3:0]            commit_slot,
    input  logic [4:0]            commit_m,
    input  logic [4:0]            commit_n,
    input  logic [ADDR_WIDTH-1:0] commit_addr,
    input  logic                  free_req,
    input  logic [3:0]            free_slot,
    input  logic                  timeout_reset,
    input  logic [3:0]            qry_slot,
    output logic                  qry_valid,
    output logic [4:0]            qry_m,
    output logic [4:0]            qry_n,
    output logic [ADDR_WIDTH-1:0] qry_addr,
    output logic [15:0]           valid_mask,
    output logic [4:0]            valid_count,
    output logic                  alloc_full,
    output logic                  evict_pulse,
    output logic                  commit_err
);

    localparam logic [1:0] ST_FREE  = 2'd0;
    localparam logic [1:0] ST_RES   = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    typedef enum logic [1:0] {IDLE, SCAN, GRANT, HOLD} fsm_t;

    fsm_t        state_r;
    logic [1:0]  status_r [16];
    logic [4:0]  m_r [16];
    logic [4:0]  n_r [16];
    logic [3:0]  victim_ptr_r;
    logic [3:0]  pick_r;

    logic [1:0]  status_nxt_s [16];
    logic [4:0]  m_nxt_s [16];
    logic [4:0]  n_nxt_s [16];
    logic [15:0] free_now_s;
    logic [15:0] valid_now_s;
    logic [15:0] valid_nxt_s;
    logic [15:0] res_nxt_s;
    logic [4:0]  free_hit_s;
    logic [4:0]  victim_hit_s;
    logic        pick_found_s;
    logic        pick_evict_s;
    logic [3:0]  pick_s;
    logic        reserve_s;
    logic        commit_ok_s;

    // Base element address of a slot: slot index in bits [11:8], zero elsewhere.
    function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [3:0] s);
        logic [ADDR_WIDTH-1:0] a;
        a = '0;
        a[11:8] = s;
        return a;
    endfunction

    // First set bit of mask at or after start, circular; returns {found, index}.
    function automatic logic [4:0] first_set_from(input logic [15:0] mask, input logic [3:0] start);
        logic [4:0] res;
        logic [3:0] idx;
        res = 5'd0;
        for (int k = 15; k >= 0; k--) begin
            idx = start + 4'(k);
            if (mask[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Number of set bits in a 16-bit mask.
    function automatic logic [4:0] popcount16(input logic [15:0] mask);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(mask[i]);
        end
        return c;
    endfunction

    // Current-state occupancy masks used by the scan.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            free_now_s[i]  = (status_r[i] == ST_FREE);
            valid_now_s[i] = (status_r[i] == ST_VALID);
        end
    end

    // Slot choice for SCAN: lowest free slot first, otherwise round-robin victim.
    always_comb begin
        free_hit_s   = first_set_from(free_now_s, 4'd0);
        victim_hit_s = first_set_from(valid_now_s, victim_ptr_r);
        if (free_hit_s[4]) begin
            pick_found_s = 1'b1;
            pick_evict_s = 1'b0;
            pick_s       = free_hit_s[3:0];
        end else begin
            pick_found_s = victim_hit_s[4];
            pick_evict_s = victim_hit_s[4];
            pick_s       = victim_hit_s[3:0];
        end
        reserve_s = (state_r == SCAN) && pick_found_s && !timeout_reset;
    end

    // Commit acceptance; a same-slot free always beats the commit.
    always_comb begin
        if (commit_req && !timeout_reset
            && (status_r[commit_slot] == ST_RES)
            && (commit_m >= 5'd1) && (commit_m <= 5'd16)
            && (commit_n >= 5'd1) && (commit_n <= 5'd16)
            && (commit_addr == slot_base(commit_slot))
            && !(free_req && (free_slot == commit_slot))) begin
            commit_ok_s = 1'b1;
        end else begin
            commit_ok_s = 1'b0;
        end
    end

    // Next slot table: timeout, then reservation, free, commit in that priority.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            if (timeout_reset) begin
                status_nxt_s[i] = (status_r[i] == ST_RES) ? ST_FREE : status_r[i];
            end else if (reserve_s && (pick_s == 4'(i))) begin
                status_nxt_s[i] = ST_RES;
            end else if (free_req && (free_slot == 4'(i))) begin
                status_nxt_s[i] = ST_FREE;
            end else if (commit_ok_s && (commit_slot == 4'(i))) begin
                status_nxt_s[i] = ST_VALID;
            end else begin
                status_nxt_s[i] = status_r[i];
            end
            if (commit_ok_s && (commit_slot == 4'(i))) begin
                m_nxt_s[i] = commit_m;
                n_nxt_s[i] = commit_n;
            end else begin
                m_nxt_s[i] = m_r[i];
                n_nxt_s[i] = n_r[i];
            end
            res_nxt_s[i]   = (status_nxt_s[i] == ST_RES);
            valid_nxt_s[i] = (status_nxt_s[i] == ST_VALID);
        end
    end

    // Slot table and the status summary outputs derived from its next value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                status_r[i] <= ST_FREE;
                m_r[i]      <= 5'd0;
                n_r[i]      <= 5'd0;
            end
            valid_mask  <= 16'd0;
            valid_count <= 5'd0;
            alloc_full  <= 1'b0;
            commit_err  <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                status_r[i] <= status_nxt_s[i];
                m_r[i]      <= m_nxt_s[i];
                n_r[i]      <= n_nxt_s[i];
            end
            valid_mask  <= valid_nxt_s;
            valid_count <= popcount16(valid_nxt_s);
            alloc_full  <= (res_nxt_s == 16'hFFFF);
            commit_err  <= commit_req && !timeout_reset && !commit_ok_s;
        end
    end

    // Registered query port reading the table as it stood at the sampling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qry_valid <= 1'b0;
            qry_m     <= 5'd0;
            qry_n     <= 5'd0;
            qry_addr  <= '0;
        end else if (status_r[qry_slot] == ST_VALID) begin
            qry_valid <= 1'b1;
            qry_m     <= m_r[qry_slot];
            qry_n     <= n_r[qry_slot];
            qry_addr  <= slot_base(qry_slot);
        end else begin
            qry_valid <= 1'b0;
            qry_m     <= 5'd0;
            qry_n     <= 5'd0;
            qry_addr  <= '0;
        end
    end

    // Grant FSM: one grant per request episode, victim pointer advances on reuse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            alloc_valid  <= 1'b0;
            alloc_slot   <= 4'd0;
            alloc_addr   <= '0;
            evict_pulse  <= 1'b0;
            victim_ptr_r <= 4'd0;
            pick_r       <= 4'd0;
        end else if (timeout_reset) begin
            state_r     <= IDLE;
            alloc_valid <= 1'b0;
            evict_pulse <= 1'b0;
        end else begin
            alloc_valid <= 1'b0;
            evict_pulse <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (alloc_req) state_r <= SCAN;
                end
                SCAN: begin
                    if (pick_found_s) begin
                        pick_r  <= pick_s;
                        state_r <= GRANT;
                        if (pick_evict_s) begin
                            victim_ptr_r <= pick_s + 4'd1;
                            evict_pulse  <= 1'b1;
                        end
                    end else if (!alloc_req) begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    alloc_valid <= 1'b1;
                    alloc_slot  <= pick_r;
                    alloc_addr  <= slot_base(pick_r);
                    state_r     <= HOLD;
                end
                HOLD: begin
                    if (!alloc_req) state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_slot_manager.sv
// Self-checking bench for matrix_slot_manager: directed scenarios with literal
// expectations plus a randomized run against a slot-table reference model.
module tb_matrix_slot_manager;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_req;
    logic          alloc_valid;
    logic [3:0]    alloc_slot;
    logic [AW-1:0] alloc_addr;
    logic          commit_req;
    logic [3:0]    commit_slot;
    logic [4:0]    commit_m;
    logic [4:0]    commit_n;
    logic [AW-1:0] commit_addr;
    logic          free_req;
    logic [3:0]    free_slot;
    logic          timeout_reset;
    logic [3:0]    qry_slot;
    logic          qry_valid;
    logic [4:0]    qry_m;
    logic [4:0]    qry_n;
    logic [AW-1:0] qry_addr;
    logic [15:0]   valid_mask;
    logic [4:0]    valid_count;
    logic          alloc_full;
    logic          evict_pulse;
    logic          commit_err;

    matrix_slot_manager #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req),
        .alloc_valid(alloc_valid), .alloc_slot(alloc_slot), .alloc_addr(alloc_addr),
        .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m),
        .commit_n(commit_n), .commit_addr(commit_addr),
        .free_req(free_req), .free_slot(free_slot), .timeout_reset(timeout_reset),
        .qry_slot(qry_slot), .qry_valid(qry_valid), .qry_m(qry_m), .qry_n(qry_n),
        .qry_addr(qry_addr), .valid_mask(valid_mask), .valid_count(valid_count),
        .alloc_full(alloc_full), .evict_pulse(evict_pulse), .commit_err(commit_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: slot status 0=FREE 1=RESERVED 2=VALID; fsm 0..3 = IDLE/SCAN/GRANT/HOLD
    int st [16];
    int mm [16];
    int nn [16];
    int vptr;
    int fsm;
    int pick;
    int e_av, e_slot, e_addr, e_qv, e_qm, e_qn, e_qa, e_mask, e_cnt, e_full, e_ev, e_cerr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin st[i] = 0; mm[i] = 0; nn[i] = 0; end
        vptr = 0; fsm = 0; pick = 0;
        e_av = 0; e_slot = 0; e_addr = 0; e_qv = 0; e_qm = 0; e_qn = 0; e_qa = 0;
        e_mask = 0; e_cnt = 0; e_full = 0; e_ev = 0; e_cerr = 0;
    endtask

    task automatic choose(output int s, output bit ev);
        s = -1; ev = 1'b0;
        for (int i = 0; i < 16; i++) if (st[i] == 0) begin s = i; break; end
        if (s < 0) begin
            for (int k = 0; k < 16; k++) begin
                if (st[(vptr + k) % 16] == 2) begin s = (vptr + k) % 16; ev = 1'b1; break; end
            end
        end
    endtask

    task automatic model_edge();
        int s, cs, fs, nres;
        bit ev, ok;
        cs = int'(commit_slot); fs = int'(free_slot);
        e_qv = (st[qry_slot] == 2) ? 1 : 0;
        e_qm = e_qv ? mm[qry_slot] : 0;
        e_qn = e_qv ? nn[qry_slot] : 0;
        e_qa = e_qv ? int'(qry_slot) * 256 : 0;
        e_av = 0; e_ev = 0; e_cerr = 0;
        if (timeout_reset) begin
            for (int i = 0; i < 16; i++) if (st[i] == 1) st[i] = 0;
            fsm = 0;
        end else begin
            ok = commit_req && st[cs] == 1 && commit_m >= 1 && commit_m <= 16 &&
                 commit_n >= 1 && commit_n <= 16 && int'(commit_addr) == cs * 256 &&
                 !(free_req && fs == cs);
            e_cerr = (commit_req && !ok) ? 1 : 0;
            choose(s, ev);
            if (ok) begin st[cs] = 2; mm[cs] = int'(commit_m); nn[cs] = int'(commit_n); end
            if (free_req) st[fs] = 0;
            case (fsm)
                0: if (alloc_req) fsm = 1;
                1: begin
                    if (s >= 0) begin
                        pick = s; st[s] = 1; fsm = 2;
                        if (ev) begin vptr = (s + 1) % 16; e_ev = 1; end
                    end else if (!alloc_req) fsm = 0;
                end
                2: begin e_av = 1; e_slot = pick; e_addr = pick * 256; fsm = 3; end
                default: if (!alloc_req) fsm = 0;
            endcase
        end
        e_mask = 0; e_cnt = 0; nres = 0;
        for (int i = 0; i < 16; i++) begin
            if (st[i] == 2) begin e_mask = e_mask | (1 << i); e_cnt++; end
            if (st[i] == 1) nres++;
        end
        e_full = (nres == 16) ? 1 : 0;
    endtask

    task automatic compare();
        chk("alloc_valid", 32'(alloc_valid), e_av);
        if (e_av != 0) begin
            chk("alloc_slot", 32'(alloc_slot), e_slot);
            chk("alloc_addr", 32'(alloc_addr), e_addr);
        end
        chk("evict_pulse", 32'(evict_pulse), e_ev);
        chk("commit_err", 32'(commit_err), e_cerr);
        chk("valid_mask", 32'(valid_mask), e_mask);
        chk("valid_count", 32'(valid_count), e_cnt);
        chk("alloc_full", 32'(alloc_full), e_full);
        chk("qry_valid", 32'(qry_valid), e_qv);
        chk("qry_m", 32'(qry_m), e_qm);
        chk("qry_n", 32'(qry_n), e_qn);
        chk("qry_addr", 32'(qry_addr), e_qa);
    endtask

    // One clock: model steps on the edge, outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic clear_strobes();
        commit_req = 1'b0; free_req = 1'b0; timeout_reset = 1'b0;
    endtask

    task automatic do_reset();
        clear_strobes();
        alloc_req = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        @(posedge clk);
        #1;
        compare();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Request until a grant pulse shows up (bounded), then drop the request.
    task automatic do_grant(output int slot, output bit saw_ev);
        bit got;
        slot = -1; saw_ev = 1'b0; got = 1'b0;
        alloc_req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (evict_pulse) saw_ev = 1'b1;
            if (alloc_valid) begin slot = int'(alloc_slot); got = 1'b1; break; end
        end
        if (!got) chk("grant_timeout", 32'd0, 32'd1);
        alloc_req = 1'b0;
        cycle();
    endtask

    task automatic do_commit(input int s, input int m, input int n, input int addr);
        commit_req = 1'b1; commit_slot = 4'(s); commit_m = 5'(m); commit_n = 5'(n);
        commit_addr = AW'(addr);
        cycle();
        commit_req = 1'b0;
    endtask

    initial begin
        int slot, first, pulses, cs;
        bit ev;
        int q[$];
        rst = 1'b1; alloc_req = 1'b0; clear_strobes();
        commit_slot = 4'd0; commit_m = 5'd0; commit_n = 5'd0; commit_addr = '0;
        free_slot = 4'd0; qry_slot = 4'd0;

        // Reset values
        do_reset();
        chk("rst_valid_mask", 32'(valid_mask), 32'd0);
        chk("rst_alloc_slot", 32'(alloc_slot), 32'd0);
        chk("rst_alloc_addr", 32'(alloc_addr), 32'd0);

        // First grant: sampled at edge 1, pulse after edge 3, exactly one pulse
        alloc_req = 1'b1; first = -1; pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            cycle();
            if (alloc_valid) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    chk("first_slot", 32'(alloc_slot), 32'd0);
                    chk("first_addr", 32'(alloc_addr), 32'h000);
                end
            end
        end
        chk("grant_latency", first, 32'd3);
        chk("single_pulse", pulses, 32'd1);
        alloc_req = 1'b0;
        cycle();

        // Commit slot 0 (3x4), then query it
        do_commit(0, 3, 4, 0);
        chk("commit0_mask", 32'(valid_mask), 32'h0001);
        chk("commit0_count", 32'(valid_count), 32'd1);
        qry_slot = 4'd0;
        cycle();
        chk("qry0_valid", 32'(qry_valid), 32'd1);
        chk("qry0_m", 32'(qry_m), 32'd3);
        chk("qry0_n", 32'(qry_n), 32'd4);

        // Rejected commits: slot 2 still FREE, then m=17 on reserved slot 1
        do_commit(2, 1, 1, 32'h200);
        chk("commit_free_err", 32'(commit_err), 32'd1);
        chk("commit_free_mask", 32'(valid_mask), 32'h0001);
        do_grant(slot, ev);
        chk("grant_slot1", slot, 32'd1);
        do_commit(1, 17, 4, 32'h100);
        chk("commit_m17_err", 32'(commit_err), 32'd1);
        chk("commit_m17_mask", 32'(valid_mask), 32'h0001);
        do_commit(1, 16, 16, 32'h100);
        chk("commit_m16_err", 32'(commit_err), 32'd0);
        chk("commit_m16_mask", 32'(valid_mask), 32'h0003);

        // All 16 VALID: reuse starts at slot 0, then slot 1
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_grant(slot, ev);
            do_commit(i, i + 1, 16 - i, i * 256);
        end
        chk("full_valid_mask", 32'(valid_mask), 32'hFFFF);
        chk("full_valid_count", 32'(valid_count), 32'd16);
        do_grant(slot, ev);
        chk("evict_slot0", slot, 32'd0);
        chk("evict_pulse0", 32'(ev), 32'd1);
        do_grant(slot, ev);
        chk("evict_slot1", slot, 32'd1);

        // All 16 RESERVED: no grant, alloc_full; timeout frees them
        do_reset();
        for (int i = 0; i < 16; i++) do_grant(slot, ev);
        alloc_req = 1'b1; pulses = 0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (alloc_valid) pulses++;
        end
        chk("full_no_grant", pulses, 32'd0);
        chk("alloc_full_set", 32'(alloc_full), 32'd1);
        timeout_reset = 1'b1; alloc_req = 1'b0;
        cycle();
        timeout_reset = 1'b0;
        chk("timeout_full_clr", 32'(alloc_full), 32'd0);
        do_grant(slot, ev);
        chk("timeout_regrant", slot, 32'd0);

        // Same-cycle free and commit on slot 5
        do_reset();
        for (int i = 0; i < 6; i++) do_grant(slot, ev);
        free_req = 1'b1; free_slot = 4'd5;
        do_commit(5, 2, 2, 32'h500);
        free_req = 1'b0;
        chk("free_commit_err", 32'(commit_err), 32'd1);
        chk("free_commit_mask", 32'(valid_mask), 32'h0000);
        do_commit(4, 2, 2, 32'h400);
        chk("commit4_mask", 32'(valid_mask), 32'h0010);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            clear_strobes();
            alloc_req = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                q.delete();
                for (int i = 0; i < 16; i++) if (st[i] == 1) q.push_back(i);
                if (q.size() > 0 && $urandom_range(0, 3) != 0) cs = q[$urandom_range(0, q.size() - 1)];
                else cs = $urandom_range(0, 15);
                commit_req = 1'b1;
                commit_slot = 4'(cs);
                commit_m = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 16));
                commit_n = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 16));
                commit_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'(cs * 256);
            end
            if ($urandom_range(0, 7) == 0) begin
                free_req = 1'b1;
                free_slot = (commit_req && $urandom_range(0, 1) == 1) ? commit_slot : 4'($urandom_range(0, 15));
            end
            timeout_reset = ($urandom_range(0, 99) == 0);
            qry_slot = 4'($urandom_range(0, 15));
            cycle();
        end
        clear_strobes();

        // Reset while a grant pulse is showing drops it immediately
        do_reset();
        alloc_req = 1'b1;
        first = -1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (alloc_valid) begin first = c; break; end
        end
        chk("midgrant_seen", 32'(first >= 0), 32'd1);
        alloc_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("midgrant_async_drop", 32'(alloc_valid), 32'd0);
        do_reset();
        do_grant(slot, ev);
        chk("post_reset_slot", slot, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
